// File: rtl/dma_mem_arbiter.sv
// Merges one-deep DMA request pulses and CPU Wishbone cycles onto a single
// memory port, one transaction in flight. `define ARB_DMA_PRIORITY_EN for fixed DMA priority.
module dma_mem_arbiter #(
  parameter int pADDR_WIDTH     = 32,
  parameter int pDATA_WIDTH     = 32,
  parameter int pMEM_ADDR_WIDTH = 23
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [pADDR_WIDTH-1:0]     wbs_adr_i,
  input  logic [pDATA_WIDTH-1:0]     wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic [pDATA_WIDTH-1:0]     wbs_dat_o,
  input  logic [pADDR_WIDTH-1:0]     dma_addr,
  input  logic                       dma_rw,
  input  logic                       dma_req_valid,
  input  logic [pDATA_WIDTH-1:0]     dma_wdata,
  output logic                       dma_rsp_valid,
  output logic [pDATA_WIDTH-1:0]     dma_rdata,
  output logic                       dma_overflow,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_we,
  output logic [3:0]                 mem_sel,
  output logic [pMEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [pDATA_WIDTH-1:0]     mem_wdata,
  input  logic                       mem_rsp_valid,
  input  logic [pDATA_WIDTH-1:0]     mem_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  logic [1:0]                 state_q, state_d;
  logic                       owner_q, owner_d;
  logic                       hold_valid_q, hold_valid_d;
  logic [pMEM_ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic                       hold_rw_q, hold_rw_d;
  logic [pDATA_WIDTH-1:0]     hold_wdata_q, hold_wdata_d;
  logic                       overflow_q, overflow_d;
  logic                       mem_we_q, mem_we_d;
  logic [3:0]                 mem_sel_q, mem_sel_d;
  logic [pMEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [pDATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic [pDATA_WIDTH-1:0]     wbs_dat_q, wbs_dat_d;
  logic [pDATA_WIDTH-1:0]     dma_rdata_q, dma_rdata_d;

  logic cpu_pending;
  logic grant_valid;
  logic grant_dma;
  logic unused_addr_bits;

  assign cpu_pending      = wbs_cyc_i & wbs_stb_i;
  assign grant_valid      = cpu_pending | hold_valid_q;
  assign unused_addr_bits = ^{wbs_adr_i[pADDR_WIDTH-1:pMEM_ADDR_WIDTH],
                              dma_addr[pADDR_WIDTH-1:pMEM_ADDR_WIDTH]};

`ifdef ARB_DMA_PRIORITY_EN
  assign grant_dma = hold_valid_q;
`else
  logic last_grant_q, last_grant_d;

  // last_grant only moves on a tie, so successive ties alternate winners.
  always_comb begin
    grant_dma    = hold_valid_q;
    last_grant_d = last_grant_q;
    if (cpu_pending && hold_valid_q) begin
      grant_dma = (last_grant_q == OWN_CPU);
      if (state_q == ST_IDLE) last_grant_d = grant_dma ? OWN_DMA : OWN_CPU;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) last_grant_q <= OWN_CPU;
    else          last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_rw_d    = hold_rw_q;
    hold_wdata_d = hold_wdata_q;
    overflow_d   = overflow_q;
    mem_we_d     = mem_we_q;
    mem_sel_d    = mem_sel_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wbs_dat_d    = wbs_dat_q;
    dma_rdata_d  = dma_rdata_q;

    if (dma_req_valid) begin
      if (hold_valid_q) begin
        overflow_d = 1'b1;
      end else begin
        hold_valid_d = 1'b1;
        hold_addr_d  = dma_addr[pMEM_ADDR_WIDTH-1:0];
        hold_rw_d    = dma_rw;
        hold_wdata_d = dma_wdata;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d = ST_REQ;
          if (grant_dma) begin
            owner_d     = OWN_DMA;
            mem_we_d    = hold_rw_q;
            mem_sel_d   = 4'hF;
            mem_addr_d  = hold_addr_q;
            mem_wdata_d = hold_wdata_q;
          end else begin
            owner_d     = OWN_CPU;
            mem_we_d    = wbs_we_i;
            mem_sel_d   = wbs_sel_i;
            mem_addr_d  = wbs_adr_i[pMEM_ADDR_WIDTH-1:0];
            mem_wdata_d = wbs_dat_i;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_WAIT;
          if (owner_q == OWN_DMA) hold_valid_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          state_d = ST_RESP;
          // Write responses leave the previous read data in place.
          if (!mem_we_q) begin
            if (owner_q == OWN_DMA) dma_rdata_d = mem_rdata;
            else                    wbs_dat_d   = mem_rdata;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_rw_q    <= 1'b0;
      hold_wdata_q <= '0;
      overflow_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_q    <= 4'h0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wbs_dat_q    <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_rw_q    <= hold_rw_d;
      hold_wdata_q <= hold_wdata_d;
      overflow_q   <= overflow_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wbs_dat_q    <= wbs_dat_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Handshake: mem_req_valid holds with stable fields until mem_req_ready is seen high on a rising edge.
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_we        = mem_we_q;
  assign mem_sel       = mem_sel_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign wbs_ack_o     = (state_q == ST_RESP) && (owner_q == OWN_CPU);
  assign wbs_dat_o     = wbs_dat_q;
  assign dma_rsp_valid = (state_q == ST_RESP) && (owner_q == OWN_DMA);
  assign dma_rdata     = dma_rdata_q;
  assign dma_overflow  = overflow_q;

endmodule

// File: tb/tb_dma_mem_arbiter.sv
// Bench for dma_mem_arbiter: directed cycle checks plus random CPU/DMA traffic
// against a reference memory, with a behavioural memory device on the mem port.
`timescale 1ns/1ps
module tb_dma_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 23;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]    wbs_sel_i = 4'h0;
  logic [AW-1:0] wbs_adr_i = '0;
  logic [DW-1:0] wbs_dat_i = '0;
  logic          wbs_ack_o;
  logic [DW-1:0] wbs_dat_o;
  logic [AW-1:0] dma_addr = '0;
  logic          dma_rw = 1'b0, dma_req_valid = 1'b0;
  logic [DW-1:0] dma_wdata = '0;
  logic          dma_rsp_valid;
  logic [DW-1:0] dma_rdata;
  logic          dma_overflow;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_we;
  logic [3:0]    mem_sel;
  logic [MW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rdata;

  dma_mem_arbiter #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pMEM_ADDR_WIDTH(MW)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .dma_addr(dma_addr), .dma_rw(dma_rw), .dma_req_valid(dma_req_valid),
    .dma_wdata(dma_wdata), .dma_rsp_valid(dma_rsp_valid), .dma_rdata(dma_rdata),
    .dma_overflow(dma_overflow),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  // ---------------- clock ----------------
  always #5 wb_clk_i = ~wb_clk_i;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [59:0] exp_cpu_q[$];
  logic [59:0] exp_dma_q[$];
  bit          grant_log[$];
  logic [31:0] ref_mem [logic [22:0]];
  logic [31:0] mem_store [logic [22:0]];
  logic [31:0] last_cpu_rd = '0;
  logic [31:0] last_dma_rd = '0;
  bit          tie_last = 1'b0;

  // memory device knobs and state
  bit          mem_rnd = 1'b0;
  int          fix_wait = 0, fix_dly = 1;
  bit          in_req = 1'b0;
  int          wait_cnt = 0, rsp_cnt = 0, n_mem_tx = 0;
  logic        pend_we;
  logic [3:0]  pend_sel;
  logic [22:0] pend_addr;
  logic [31:0] pend_wdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [22:0] a);
    return 32'h5EED0000 ^ {9'd0, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [22:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] rd_store(input logic [22:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return dflt(a);
  endfunction

  function automatic logic [59:0] pack(input logic we, input logic [3:0] sel,
                                       input logic [22:0] a, input logic [31:0] wd);
    return {we, sel, a, wd};
  endfunction

  task automatic ref_write(input logic [22:0] a, input logic [3:0] sel, input logic [31:0] wd);
    ref_mem[a] = merge(rd_ref(a), wd, sel);
  endtask

  task automatic preload(input logic [22:0] a, input logic [31:0] d);
    ref_mem[a]   = d;
    mem_store[a] = d;
  endtask

  // Accepted request must be the oldest outstanding request of one of the owners.
  task automatic log_tx();
    logic [59:0] act;
    bit matched;
    act = pack(mem_we, mem_sel, mem_addr, mem_wdata);
    matched = 1'b0;
    if (exp_dma_q.size() > 0 && exp_dma_q[0] == act) begin
      void'(exp_dma_q.pop_front()); grant_log.push_back(1'b1); matched = 1'b1;
    end else if (exp_cpu_q.size() > 0 && exp_cpu_q[0] == act) begin
      void'(exp_cpu_q.pop_front()); grant_log.push_back(1'b0); matched = 1'b1;
    end
    if (!matched) $display("unexpected mem request 0x%0h", act);
    check_eq("mem_tx_match", matched, 1'b1);
    pend_we = mem_we; pend_sel = mem_sel; pend_addr = mem_addr; pend_wdata = mem_wdata;
    n_mem_tx++;
  endtask

  // ---------------- memory device ----------------
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(negedge wb_clk_i);
      mem_rsp_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          if (pend_we) begin
            mem_store[pend_addr] = merge(rd_store(pend_addr), pend_wdata, pend_sel);
            mem_rdata = $urandom;
          end else begin
            mem_rdata = rd_store(pend_addr);
          end
        end
      end
      mem_req_ready = 1'b0;
      if (wb_rst_i) begin
        in_req = 1'b0;
      end else if (mem_req_valid) begin
        if (!in_req) begin
          in_req = 1'b1;
          wait_cnt = mem_rnd ? int'($urandom_range(0, 3)) : fix_wait;
        end
        if (wait_cnt == 0) begin
          mem_req_ready = 1'b1;
          in_req = 1'b0;
          log_tx();
          rsp_cnt = mem_rnd ? int'($urandom_range(1, 4)) : fix_dly;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    wb_rst_i = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; dma_req_valid = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    last_cpu_rd = '0; last_dma_rd = '0; tie_last = 1'b0;
  endtask

  task automatic check_zero();
    check_eq("z_ack", wbs_ack_o, 0);
    check_eq("z_wbs_dat", wbs_dat_o, 0);
    check_eq("z_dma_rsp", dma_rsp_valid, 0);
    check_eq("z_dma_rdata", dma_rdata, 0);
    check_eq("z_ovf", dma_overflow, 0);
    check_eq("z_mem_valid", mem_req_valid, 0);
    check_eq("z_mem_we", mem_we, 0);
    check_eq("z_mem_sel", mem_sel, 0);
    check_eq("z_mem_addr", mem_addr, 0);
    check_eq("z_mem_wdata", mem_wdata, 0);
  endtask

  task automatic dma_pulse(input logic [31:0] a, input logic rw, input logic [31:0] wd,
                           input bit expect_mem);
    dma_addr = a; dma_rw = rw; dma_wdata = wd; dma_req_valid = 1'b1;
    if (expect_mem) begin
      exp_dma_q.push_back(pack(rw, 4'hF, a[22:0], wd));
      if (rw) ref_write(a[22:0], 4'hF, wd);
    end
    @(negedge wb_clk_i);
    dma_req_valid = 1'b0;
  endtask

  task automatic wait_dma_rsp(input logic [31:0] a, input logic rw);
    int n = 0;
    while (!dma_rsp_valid && n < 300) begin @(negedge wb_clk_i); n++; end
    check_eq("dma_rsp_seen", dma_rsp_valid, 1);
    if (dma_rsp_valid) begin
      if (rw) check_eq("dma_wr_hold", dma_rdata, last_dma_rd);
      else begin
        check_eq("dma_rdata", dma_rdata, rd_ref(a[22:0]));
        last_dma_rd = rd_ref(a[22:0]);
      end
    end
  endtask

  task automatic cpu_xfer(input logic [31:0] a, input logic we, input logic [3:0] sel,
                          input logic [31:0] wd);
    int n = 0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = a; wbs_dat_i = wd;
    exp_cpu_q.push_back(pack(we, sel, a[22:0], wd));
    if (we) ref_write(a[22:0], sel, wd);
    while (!wbs_ack_o && n < 300) begin @(negedge wb_clk_i); n++; end
    check_eq("cpu_ack_seen", wbs_ack_o, 1);
    if (wbs_ack_o) begin
      if (we) check_eq("cpu_wr_hold", wbs_dat_o, last_cpu_rd);
      else begin
        check_eq("cpu_rdata", wbs_dat_o, rd_ref(a[22:0]));
        last_cpu_rd = rd_ref(a[22:0]);
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge wb_clk_i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acks, rsps, vcyc, first_v, ack_at, n0;
    bit exp_first;
    logic [31:0] a, wd;

    do_reset();
    check_zero();

    // DMA read: exact latency
    preload(23'h000010, 32'hCAFE0001);
    mem_rnd = 1'b0; fix_wait = 0; fix_dly = 2;
    dma_pulse(32'h38000010, 1'b0, 32'h0, 1'b1);
    check_eq("t1_valid_t1", mem_req_valid, 0);
    @(negedge wb_clk_i);
    check_eq("t1_valid_t2", mem_req_valid, 1);
    check_eq("t1_addr", mem_addr, 23'h000010);
    check_eq("t1_we", mem_we, 0);
    check_eq("t1_sel", mem_sel, 4'hF);
    @(negedge wb_clk_i);
    check_eq("t1_valid_t3", mem_req_valid, 0);
    @(negedge wb_clk_i);
    check_eq("t1_rsp_t4", dma_rsp_valid, 0);
    @(negedge wb_clk_i);
    check_eq("t1_rsp_t5", dma_rsp_valid, 1);
    check_eq("t1_rdata", dma_rdata, 32'hCAFE0001);
    check_eq("t1_no_ack", wbs_ack_o, 0);
    @(negedge wb_clk_i);
    check_eq("t1_rsp_t6", dma_rsp_valid, 0);
    check_eq("t1_rdata_hold", dma_rdata, 32'hCAFE0001);
    last_dma_rd = 32'hCAFE0001;

    // CPU write with 3 stall cycles
    fix_wait = 3; fix_dly = 1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_sel_i = 4'b0011; wbs_adr_i = 32'h38000004; wbs_dat_i = 32'h12345678;
    exp_cpu_q.push_back(pack(1'b1, 4'b0011, 23'h000004, 32'h12345678));
    ref_write(23'h000004, 4'b0011, 32'h12345678);
    acks = 0; rsps = 0; vcyc = 0; first_v = -1; ack_at = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge wb_clk_i);
      if (mem_req_valid) begin
        if (first_v < 0) first_v = i;
        vcyc++;
        check_eq("t2_addr", mem_addr, 23'h000004);
        check_eq("t2_we", mem_we, 1);
        check_eq("t2_sel", mem_sel, 4'b0011);
        check_eq("t2_wdata", mem_wdata, 32'h12345678);
      end
      if (dma_rsp_valid) rsps++;
      if (wbs_ack_o) begin
        acks++; ack_at = i;
        check_eq("t2_dat_hold", wbs_dat_o, last_cpu_rd);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      end
    end
    check_eq("t2_first_valid", first_v, 0);
    check_eq("t2_valid_cycles", vcyc, 4);
    check_eq("t2_ack_count", acks, 1);
    check_eq("t2_ack_cycle", ack_at, 5);
    check_eq("t2_no_dma_rsp", rsps, 0);

    // Simultaneous requests after reset
    do_reset();
    mem_rnd = 1'b1;
    for (int r = 0; r < 4; r++) begin
      grant_log.delete();
      fork
        begin
          dma_pulse(32'h38001100 + r * 4, 1'b0, 32'h0, 1'b1);
          wait_dma_rsp(32'h38001100 + r * 4, 1'b0);
        end
        begin
          @(negedge wb_clk_i);
          cpu_xfer(32'h38000100 + r * 4, 1'b0, 4'hF, $urandom);
        end
      join
`ifdef ARB_DMA_PRIORITY_EN
      exp_first = 1'b1;
`else
      exp_first = (tie_last == 1'b0);
      tie_last  = exp_first;
`endif
      check_eq("tie_count", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
        check_eq("tie_first", grant_log[0], exp_first);
        check_eq("tie_second", grant_log[1], !exp_first);
      end
      repeat (2) @(negedge wb_clk_i);
    end

    // Overflow while the CPU transaction is stalled
    do_reset();
    mem_rnd = 1'b0; fix_wait = 8; fix_dly = 1;
    n0 = n_mem_tx;
    fork
      cpu_xfer(32'h38000020, 1'b1, 4'hF, 32'hA1A2A3A4);
      begin
        repeat (2) @(negedge wb_clk_i);
        dma_pulse(32'h38001040, 1'b0, 32'h0, 1'b1);
        check_eq("ovf_clear_before", dma_overflow, 0);
        @(negedge wb_clk_i);
        dma_pulse(32'h38001044, 1'b1, 32'hBAD0BAD0, 1'b0);
        check_eq("ovf_set", dma_overflow, 1);
        wait_dma_rsp(32'h38001040, 1'b0);
      end
    join
    repeat (10) @(negedge wb_clk_i);
    check_eq("ovf_sticky", dma_overflow, 1);
    check_eq("ovf_mem_tx", n_mem_tx - n0, 2);

    // Reset while waiting for the memory response
    fix_wait = 0; fix_dly = 6;
    dma_pulse(32'h38001200, 1'b0, 32'h0, 1'b1);
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    last_cpu_rd = '0; last_dma_rd = '0; tie_last = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_zero();
      @(negedge wb_clk_i);
    end

    // DMA write stream
    mem_rnd = 1'b1;
    rsps = 0;
    for (int i = 0; i < 11; i++) begin
      wd = $urandom;
      dma_pulse(32'h38002000 + i * 4, 1'b1, wd, 1'b1);
      wait_dma_rsp(32'h38002000 + i * 4, 1'b1);
      if (dma_rsp_valid) rsps++;
      repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
    end
    check_eq("stream_rsps", rsps, 11);
    repeat (2) @(negedge wb_clk_i);
    check_eq("stream_drained", exp_dma_q.size(), 0);
    for (int i = 0; i < 11; i++) begin
      a = 32'h38002000 + i * 4;
      check_eq("stream_mem", mem_store[a[22:0]], ref_mem[a[22:0]]);
    end

    // Random concurrent traffic
    fork
      for (int i = 0; i < 30; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge wb_clk_i);
        cpu_xfer(32'h38000000 + $urandom_range(0, 15) * 4, 1'($urandom_range(0, 1)),
                 4'($urandom_range(1, 15)), $urandom);
      end
      for (int i = 0; i < 30; i++) begin
        logic rw;
        logic [31:0] da;
        rw = 1'($urandom_range(0, 1));
        da = 32'h38001000 + $urandom_range(0, 15) * 4;
        dma_pulse(da, rw, $urandom, 1'b1);
        wait_dma_rsp(da, rw);
        repeat ($urandom_range(0, 3)) @(negedge wb_clk_i);
      end
    join
    repeat (10) @(negedge wb_clk_i);
    check_eq("final_cpu_q", exp_cpu_q.size(), 0);
    check_eq("final_dma_q", exp_dma_q.size(), 0);
    check_eq("final_no_ovf", dma_overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/dma_mem_arbiter.md
Name: dma_mem_arbiter

Overview:
- Sits directly downstream of the DMA engine's arbiter-side request port (addr / rw / out_valid / out_data, returning in_valid / in_data).
- Merges DMA traffic with CPU Wishbone traffic onto a single request/response port of the user-project memory controller (SDRAM/BRAM), one transaction outstanding at a time.
- Captures the DMA's single-cycle request pulses and returns one response pulse per request, for reads and writes alike.

Parameters:
- pADDR_WIDTH, 32, width of the Wishbone and DMA addresses.
- pDATA_WIDTH, 32, data width on all ports.
- pMEM_ADDR_WIDTH, 23, memory-side address width; mem_addr = request address [pMEM_ADDR_WIDTH-1:0].

Ports:
- wb_clk_i  in  1  clock; all logic on the rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_cyc_i  in  1  CPU Wishbone cycle.
- wbs_stb_i  in  1  CPU Wishbone strobe.
- wbs_we_i  in  1  CPU write enable.
- wbs_sel_i  in  4  CPU byte selects.
- wbs_adr_i  in  pADDR_WIDTH  CPU address.
- wbs_dat_i  in  pDATA_WIDTH  CPU write data.
- wbs_ack_o  out  1  CPU acknowledge, one-cycle pulse.
- wbs_dat_o  out  pDATA_WIDTH  CPU read data.
- dma_addr  in  pADDR_WIDTH  DMA request address.
- dma_rw  in  1  1 = write, 0 = read.
- dma_req_valid  in  1  DMA request, one-cycle pulse.
- dma_wdata  in  pDATA_WIDTH  DMA write data.
- dma_rsp_valid  out  1  response to DMA, one-cycle pulse.
- dma_rdata  out  pDATA_WIDTH  read data to DMA.
- dma_overflow  out  1  sticky: a DMA pulse arrived while the hold register was full.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_we  out  1  memory write.
- mem_sel  out  4  byte enables (4'hF for DMA).
- mem_addr  out  pMEM_ADDR_WIDTH  memory address.
- mem_wdata  out  pDATA_WIDTH  memory write data.
- mem_rsp_valid  in  1  memory response; reads and writes both respond.
- mem_rdata  in  pDATA_WIDTH  memory read data.

Behaviour:
- Reset values:
  - All outputs 0; hold register empty; state IDLE; last_grant = CPU, so the first tie goes to DMA.
  - Reset mid-transaction abandons the transaction; any later mem_rsp_valid seen in IDLE is discarded.
- DMA hold register:
  - dma_req_valid at edge T captures {addr, rw, wdata}; dma_pending = 1 from T+1.
  - A pulse while dma_pending = 1 is dropped and sets dma_overflow, which is cleared only by reset.
- CPU pending = wbs_cyc_i & wbs_stb_i, held by the master until ack.
- FSM:
  - IDLE: if exactly one requester is pending, grant it. If both are pending, grant the one not equal to last_grant, then update last_grant. On grant, latch mem_* from the winner and go to REQ.
  - REQ: mem_req_valid = 1 with stable fields until a cycle where mem_req_ready = 1, then go to WAIT. A DMA grant clears dma_pending at the handshake.
  - WAIT: on mem_rsp_valid, register mem_rdata into the winner's data output and go to RESP.
  - RESP: one cycle. Pulse wbs_ack_o (with wbs_dat_o) or dma_rsp_valid (with dma_rdata), then return to IDLE.
- Latency:
  - DMA pulse at T → mem_req_valid from T+2 if idle.
  - mem_rsp_valid at R → response pulse at R+1; next grant decision at R+2.
- Data hold: wbs_dat_o and dma_rdata keep their value until the next response of the same owner.
- Write responses return the previous read data (don't-care to consumers).
- RESP→IDLE gap: the CPU master drops stb one cycle after ack, so the same CPU request is never re-granted.
- A new DMA pulse during RESP or IDLE is captured normally.

Optional Feature:
- ARB_DMA_PRIORITY_EN:
  - Defined: fixed priority; the DMA always wins ties and last_grant is unused.
  - Undefined: round-robin as above.

Test Plan:
- DMA read only:
  - Stimulus: dma_req_valid at T, addr 0x38000010, mem_req_ready = 1, mem_rsp_valid at T+4 with 0xCAFE0001.
  - Expect: mem_req_valid at T+2 with mem_addr = 0x000010 and mem_we = 0; dma_rsp_valid at T+5 with dma_rdata = 0xCAFE0001.
- CPU write:
  - Stimulus: wbs write 0x38000004 = 0x12345678, sel 4'b0011; mem_req_ready low for 3 cycles.
  - Expect: mem_req_valid held 4 cycles with stable fields, mem_sel = 0011; exactly one wbs_ack_o after mem_rsp_valid.
- Simultaneous CPU and DMA requests after reset:
  - Expect: DMA served first, CPU next.
  - Repeat 4 times: grants alternate (reversed order under ARB_DMA_PRIORITY_EN: DMA every tie).
- Overflow:
  - Stimulus: two dma_req_valid pulses 1 cycle apart while the CPU transaction is stalled.
  - Expect: dma_overflow = 1; only the first DMA request reaches memory.
- Reset mid-transaction:
  - Stimulus: wb_rst_i asserted in WAIT; mem_rsp_valid arrives 2 cycles after release.
  - Expect: no wbs_ack_o and no dma_rsp_valid; all outputs 0.
- DMA write stream:
  - Stimulus: 11 writes, each issued after the previous dma_rsp_valid, addresses +4.
  - Expect: 11 memory writes in order with matching data; 11 response pulses.
